// File: rtl/pprm_inverter_arbiter.sv
// pprm_inverter_arbiter
//   Shares one GF(2^8) inverter datapath (field polynomial 0x11B, 0 maps to 0)
//   among N_REQ byte requesters. A round-robin arbiter admits at most one byte
//   per cycle into a three-stage registered pipe. Results leave in acceptance
//   order on a single tagged response port that honours backpressure.
//
//   Ports
//     clk         in   rising-edge clock
//     reset_n     in   asynchronous active-low reset
//     req_valid   in   [N_REQ]    requester i presents a byte
//     req_data    in   [8*N_REQ]  byte of requester i in bits [8*i+7:8*i]
//     req_ready   out  [N_REQ]    one-hot grant (combinational)
//     resp_valid  out             result present on resp_data/resp_id
//     resp_data   out  [8]        multiplicative inverse of the accepted byte
//     resp_id     out  [ID_W]     index of the requester that issued it
//     resp_ready  in              consumer takes the result
//     busy        out             some pipeline stage holds a valid entry

// One requester's slice of the round-robin pick: it wins when it is valid and
// no valid requester sits between ptr (inclusive) and itself in scan order.
module pprm_rr_lane #(
    parameter int N_REQ = 4,
    parameter int IDX   = 0,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] ptr,
    output logic             win
);

    logic blocked;

    always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            // j lies ahead of IDX in the scan that starts at ptr and wraps.
            if (((int'(ptr) <= IDX) ? (j >= int'(ptr) && j < IDX)
                                    : (j >= int'(ptr) || j < IDX)) && valid[j])
                blocked = 1'b1;
        end
        win = valid[IDX] & ~blocked;
    end

endmodule

module pprm_inverter_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               resp_valid,
    output logic [7:0]         resp_data,
    output logic [ID_W-1:0]    resp_id,
    input  logic               resp_ready,
    output logic               busy
);

    localparam int PTR_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int STAGES = 3;

    // The inverse is x^254, built as x^240 * x^12 * x^2 so each stage does a
    // bounded amount of multiply/square work.
    //   S1: a = x,     b = x^2,  c = x^3
    //   S2: a = x^12,  b = x^2,  d = x^15
    //   S3: y = x^254
    typedef struct packed {
        logic [7:0]      a;
        logic [7:0]      b;
        logic [7:0]      c;
        logic [ID_W-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [7:0]      a;
        logic [7:0]      b;
        logic [7:0]      d;
        logic [ID_W-1:0] id;
    } s2_t;

    typedef struct packed {
        logic [7:0]      y;
        logic [ID_W-1:0] id;
    } s3_t;

    // GF(2^8) product reduced by x^8+x^4+x^3+x+1, written as a sum of
    // AND-gated shifted copies of x.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) acc = acc ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // x^(2^n): repeated squaring (linear over GF(2)).
    function automatic logic [7:0] gf_sqn(input logic [7:0] x, input int n);
        logic [7:0] t;
        t = x;
        for (int k = 0; k < n; k++) t = gf_mul(t, t);
        return t;
    endfunction

    logic [STAGES:1]   vld_pipe;
    s1_t               s1_q, s1_n;
    s2_t               s2_q, s2_n;
    s3_t               s3_q, s3_n;
    logic [PTR_W-1:0]  ptr;
    logic [N_REQ-1:0]  win;
    logic              advance;
    logic              accept;
    logic [ID_W-1:0]   gid;
    logic [7:0]        gdata;
    logic [PTR_W-1:0]  gptr;
    logic [7:0]        c4;
    logic [7:0]        d16;

    // A stalled S3 freezes the whole pipe, bubbles included.
    assign advance = ~vld_pipe[STAGES] | resp_ready;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        pprm_rr_lane #(
            .N_REQ (N_REQ),
            .IDX   (gi),
            .PTR_W (PTR_W)
        ) u_lane (
            .valid (req_valid),
            .ptr   (ptr),
            .win   (win[gi])
        );
    end

    // Gating with reset_n keeps the grant low while the pipe is held in reset.
    assign req_ready = (reset_n && advance) ? win : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        gid   = '0;
        gdata = 8'h00;
        gptr  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                gid   = ID_W'(i);
                gdata = req_data[8*i +: 8];
                gptr  = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_comb begin
        s1_n.a  = gdata;
        s1_n.b  = gf_mul(gdata, gdata);
        s1_n.c  = gf_mul(gdata, s1_n.b);
        s1_n.id = gid;

        c4      = gf_sqn(s1_q.c, 2);
        s2_n.a  = c4;
        s2_n.b  = s1_q.b;
        s2_n.d  = gf_mul(gf_mul(c4, s1_q.a), s1_q.b);
        s2_n.id = s1_q.id;

        d16     = gf_sqn(s2_q.d, 4);
        s3_n.y  = gf_mul(gf_mul(d16, s2_q.a), s2_q.b);
        s3_n.id = s2_q.id;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            ptr      <= '0;
        end else begin
            if (advance) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], accept};
                s1_q     <= s1_n;
                s2_q     <= s2_n;
                s3_q     <= s3_n;
            end
            if (accept) ptr <= gptr;
        end
    end

    assign resp_valid = vld_pipe[STAGES];
    assign resp_data  = s3_q.y;
    assign resp_id    = s3_q.id;
    assign busy       = |vld_pipe;

endmodule

// File: tb/tb_pprm_inverter_arbiter.sv
module tb_pprm_inverter_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [7:0]     resp_data;
    logic [IDW-1:0] resp_id;
    logic           resp_ready;
    logic           busy;

    pprm_inverter_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]     d;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t           sb[$];
    logic [7:0]     txq[N][$];
    int             grant_log[$];
    logic [3:1]     mv;
    int             mptr;
    int             tests = 0;
    int             fails = 0;
    int             popped;
    logic [7:0]     last_d;
    logic [IDW-1:0] last_id;
    logic           rnd_ready;
    logic [7:0]     hold_d;
    logic [IDW-1:0] hold_id;
    int             p0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Brute-force search for y with x*y = 1; 0 has no inverse and maps to 0.
    function automatic logic [7:0] inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
        return r;
    endfunction

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0);
        for (int i = 0; i < N; i++)
            if (txq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (txq[i].size() != 0);
            req_data[8*i +: 8] = (txq[i].size() != 0) ? txq[i][0] : 8'h00;
        end
        if (rnd_ready) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // One clock: drive, check at the falling edge against the model, update model.
    task automatic cycle();
        logic         adv;
        logic [N-1:0] er;
        int           g;
        int           j;
        exp_t         e;
        logic [7:0]   tmp;
        drive();
        @(negedge clk);
        adv = !mv[3] || resp_ready;
        er  = '0;
        g   = -1;
        if (adv) begin
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("resp_valid", 32'(resp_valid), 32'(mv[3]));
        chk("busy", 32'(busy), 32'(|mv));
        if (resp_valid && resp_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_data", 32'(resp_data), 32'(e.d));
                chk("resp_id", 32'(resp_id), 32'(e.id));
                last_d  = resp_data;
                last_id = resp_id;
                popped++;
            end
        end
        if (g >= 0) begin
            e.d  = inv(txq[g][0]);
            e.id = IDW'(g);
            sb.push_back(e);
            tmp  = txq[g].pop_front();
            grant_log.push_back(g);
            mptr = (g == N - 1) ? 0 : g + 1;
        end
        if (adv) mv = {mv[2:1], (g >= 0)};
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc, input string tag);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            cycle();
            n++;
        end
        chk(tag, 32'(pending()), 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, held for one clock period.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        mv   = '0;
        mptr = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = '1;
        req_data   = '0;
        resp_ready = 1'b1;
        rnd_ready  = 1'b0;
        mv         = '0;
        mptr       = 0;
        popped     = 0;
        last_d     = '0;
        last_id    = '0;

        // Reset state, with every requester asserting valid.
        @(posedge clk);
        #1;
        chk("init_resp_valid", 32'(resp_valid), 32'd0);
        chk("init_resp_data", 32'(resp_data), 32'd0);
        chk("init_resp_id", 32'(resp_id), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset_n   = 1'b1;

        // Single byte from req0.
        txq[0].push_back(8'h53);
        drain(20, "single_drained");
        chk("single_data", 32'(last_d), 32'hCA);
        chk("single_id", 32'(last_id), 32'd0);

        // Back-to-back vectors from req1.
        p0 = popped;
        txq[1].push_back(8'h00);
        txq[1].push_back(8'h01);
        txq[1].push_back(8'h02);
        txq[1].push_back(8'h03);
        drain(20, "vec_drained");
        chk("vec_count", 32'(popped - p0), 32'd4);
        chk("vec_last", 32'(last_d), 32'hF6);

        // All requesters continuously valid from reset.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 5; k++) txq[i].push_back(8'(8'h40 + i * 8 + k));
        grant_log.delete();
        drain(100, "rr_drained");
        for (int k = 0; k < 8; k++)
            chk("rr_grant_order", 32'(grant_log[k]), 32'(k % N));

        // Backpressure: fill the pipe, then stall for five cycles.
        p0 = popped;
        for (int k = 0; k < 4; k++) txq[2].push_back(8'(8'h10 * (k + 1)));
        repeat (3) cycle();
        resp_ready = 1'b0;
        chk("bp_full", 32'(resp_valid), 32'd1);
        hold_d  = resp_data;
        hold_id = resp_id;
        repeat (5) begin
            cycle();
            chk("bp_hold_data", 32'(resp_data), 32'(hold_d));
            chk("bp_hold_id", 32'(resp_id), 32'(hold_id));
        end
        resp_ready = 1'b1;
        drain(30, "bp_drained");
        chk("bp_count", 32'(popped - p0), 32'd4);

        // Reset pulse with three entries in flight.
        txq[1].push_back(8'hA0);
        txq[1].push_back(8'hA1);
        txq[3].push_back(8'hB0);
        txq[3].push_back(8'hB1);
        repeat (3) cycle();
        chk("pulse_inflight", 32'(busy), 32'd1);
        do_reset();
        txq[0].push_back(8'h77);
        drive();
        #1;
        chk("pulse_next_grant", 32'(req_ready), 32'b0001);
        drain(40, "pulse_drained");

        // Exhaustive sweep with random consumer stalls.
        p0        = popped;
        rnd_ready = 1'b1;
        for (int b = 0; b < 256; b++) txq[b % N].push_back(8'(b));
        drain(3000, "exh_drained");
        rnd_ready  = 1'b0;
        resp_ready = 1'b1;
        chk("exh_count", 32'(popped - p0), 32'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
